// File: rtl/spike_decoder_pkg.sv
// Shared types, default sizes and helpers for the spike rate decoder.
package spike_decoder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int WINDOW_DEFAULT    = 1024;
    localparam int CNT_WIDTH_DEFAULT = 8;
    localparam int ISI_WIDTH_DEFAULT = 16;

    // Increment that sticks at max_val instead of wrapping. Callers pass
    // zero-extended operands and cast the result back to their own width.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input logic [31:0] max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/rate_holdreg.sv
// Output holding register for the window result: valid/ready handshake
// with a sticky overrun flag when an unaccepted result is replaced.
module rate_holdreg
    import spike_decoder_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_data,
    input  logic                 rate_ready,
    output logic [CNT_WIDTH-1:0] rate_data,
    output logic                 rate_valid,
    output logic                 overrun
);

    // A new result always wins; it only counts as an overrun when the old
    // one is still waiting and is not being taken on this same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rate_data  <= '0;
            rate_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (load) begin
            rate_data  <= load_data;
            rate_valid <= 1'b1;
            if (rate_valid && !rate_ready) begin
                overrun <= 1'b1;
            end
        end else if (rate_valid && rate_ready) begin
            rate_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: counts rising edges of a level spike over a fixed
// window and hands the count out through rate_holdreg.
// Optional inter-spike interval measurement: define SPIKE_DECODER_ISI_EN.
//
// state | meaning
// IDLE  | counters held at zero, edges ignored, waiting for en
// RUN   | window running, edges counted, result issued at window end
module spike_rate_decoder
    import spike_decoder_pkg::*;
#(
    parameter int WINDOW    = WINDOW_DEFAULT,
    parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT,
    parameter int ISI_WIDTH = ISI_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 spike_in,
    output logic [CNT_WIDTH-1:0] rate_data,
    output logic                 rate_valid,
    input  logic                 rate_ready,
    output logic                 overrun,
    output logic                 busy,
    output logic [ISI_WIDTH-1:0] isi_data,
    output logic                 isi_valid
);

    localparam int              WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [31:0]      CNT_MAX  = 32'((64'd1 << CNT_WIDTH) - 64'd1);

    state_t               state;
    state_t               state_nxt;
    logic                 spike_d;
    logic                 spike_edge;
    logic [WIN_W-1:0]     win_cnt;
    logic [WIN_W-1:0]     win_cnt_nxt;
    logic [CNT_WIDTH-1:0] spike_cnt;
    logic [CNT_WIDTH-1:0] spike_cnt_nxt;
    logic [CNT_WIDTH-1:0] spike_cnt_sat;
    logic                 load;
    logic [CNT_WIDTH-1:0] load_data;

    assign spike_edge    = spike_in & ~spike_d;
    assign spike_cnt_sat = spike_edge ? CNT_WIDTH'(sat_inc(32'(spike_cnt), CNT_MAX))
                                      : spike_cnt;
    assign busy          = (state == RUN);

    // Edge-detect delay runs in every state so the first RUN cycle sees a
    // correct previous level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spike_d <= 1'b0;
        end else begin
            spike_d <= spike_in;
        end
    end

    // State and window counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            win_cnt   <= '0;
            spike_cnt <= '0;
        end else begin
            state     <= state_nxt;
            win_cnt   <= win_cnt_nxt;
            spike_cnt <= spike_cnt_nxt;
        end
    end

    // Next state, counter updates and the result load strobe. Counters fall
    // back to zero whenever they are not explicitly advanced.
    always_comb begin
        state_nxt     = state;
        win_cnt_nxt   = '0;
        spike_cnt_nxt = '0;
        load          = 1'b0;
        load_data     = '0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (win_cnt == WIN_LAST) begin
                    // Window end still reports even if en just dropped.
                    load      = 1'b1;
                    load_data = spike_cnt_sat;
                    state_nxt = en ? RUN : IDLE;
                end else if (!en) begin
                    state_nxt = IDLE;
                end else begin
                    win_cnt_nxt   = win_cnt + WIN_W'(1);
                    spike_cnt_nxt = spike_cnt_sat;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    rate_holdreg #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_holdreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_data  (load_data),
        .rate_ready (rate_ready),
        .rate_data  (rate_data),
        .rate_valid (rate_valid),
        .overrun    (overrun)
    );

`ifdef SPIKE_DECODER_ISI_EN
    localparam logic [31:0] ISI_MAX = 32'((64'd1 << ISI_WIDTH) - 64'd1);

    logic [ISI_WIDTH-1:0] isi_cnt;
    logic                 isi_armed;
    logic [ISI_WIDTH-1:0] isi_cnt_inc;

    assign isi_cnt_inc = ISI_WIDTH'(sat_inc(32'(isi_cnt), ISI_MAX));

    // Interval measurement: the first edge of a RUN period only arms it,
    // later edges report cycles since the previous edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            isi_cnt   <= '0;
            isi_armed <= 1'b0;
            isi_data  <= '0;
            isi_valid <= 1'b0;
        end else begin
            isi_valid <= 1'b0;
            if (state == RUN) begin
                if (spike_edge) begin
                    if (isi_armed) begin
                        isi_data  <= isi_cnt_inc;
                        isi_valid <= 1'b1;
                    end
                    isi_armed <= 1'b1;
                    isi_cnt   <= '0;
                end else begin
                    isi_cnt <= isi_cnt_inc;
                end
                if (state_nxt == IDLE) begin
                    isi_armed <= 1'b0;
                    isi_cnt   <= '0;
                end
            end else begin
                isi_armed <= 1'b0;
                isi_cnt   <= '0;
            end
        end
    end
`else
    assign isi_data  = '0;
    assign isi_valid = 1'b0;
`endif

endmodule
